imem_program_loader: RTL and testbench

Writer-side companion to the fetch stage. Receives a program as a byte stream over a valid/ready handshake, assembles 16-bit instructions and writes them into instruction memory at consecutive 8-bit addresses. Holds the pipeline via `cpu_hold` until a complete, checksum-verified image is resident. Sits between the host/debug byte source and the instruction memory write port; the fetch stage remains the sole reader.

---
 rtl/imem_program_loader.sv | 135 +++++++++++++
 tb/tb_imem_program_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
`timescale 1ns/1ps
// Byte-stream program loader: assembles {HI,LO} words into instruction memory,
// verifies a trailing XOR checksum and holds the CPU until a good image is resident.
module imem_program_loader #(
    parameter int DEPTH   = 256,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        imem_we,
    output logic [7:0]  imem_addr,
    output logic [15:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [7:0]  load_count
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW:0] TIMEOUT_V = (TW + 1)'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, LEN_S, HI_S, LO_S, CHK_S, DONE_S, ERR_S
    } state_t;

    state_t        state;
    logic [7:0]    len;
    logic [7:0]    word_idx;
    logic [7:0]    hi_byte;
    logic [7:0]    checksum;
    logic [TW-1:0] timer;
    logic          xfer;
    logic          timed_out;
    logic          bad_len;
    logic          last_word;

    assign in_ready  = (state == LEN_S) || (state == HI_S) ||
                       (state == LO_S)  || (state == CHK_S);
    assign xfer      = in_valid && in_ready;
    // Fires on the idle cycle whose increment would make the count reach TIMEOUT.
    assign timed_out = (TIMEOUT != 0) && !xfer &&
                       (({1'b0, timer} + 1'b1) == TIMEOUT_V);
    assign bad_len   = (in_data == 8'd0) || ({24'd0, in_data} >= 32'(DEPTH));
    assign last_word = (word_idx == (len - 8'd1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            len        <= '0;
            word_idx   <= '0;
            hi_byte    <= '0;
            checksum   <= '0;
            timer      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            load_count <= '0;
        end else begin
            imem_we <= 1'b0;
            unique case (state)
                IDLE, DONE_S, ERR_S: begin
                    if (start) begin
                        state    <= LEN_S;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        cpu_hold <= 1'b1;
                        timer    <= '0;
                    end
                end
                default: begin
                    if (xfer) begin
                        timer <= '0;
                    end else if (timed_out) begin
                        state <= ERR_S;
                        error <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end

                    if (xfer) begin
                        case (state)
                            LEN_S: begin
                                if (bad_len) begin
                                    state <= ERR_S;
                                    error <= 1'b1;
                                end else begin
                                    len        <= in_data;
                                    word_idx   <= '0;
                                    imem_addr  <= '0;
                                    load_count <= '0;
                                    checksum   <= in_data;
                                    state      <= HI_S;
                                end
                            end
                            HI_S: begin
                                hi_byte  <= in_data;
                                checksum <= checksum ^ in_data;
                                state    <= LO_S;
                            end
                            LO_S: begin
                                checksum   <= checksum ^ in_data;
                                imem_we    <= 1'b1;
                                imem_addr  <= word_idx;
                                imem_wdata <= {hi_byte, in_data};
                                word_idx   <= word_idx + 8'd1;
                                load_count <= load_count + 8'd1;
                                state      <= last_word ? CHK_S : HI_S;
                            end
                            CHK_S: begin
                                if (in_data == checksum) begin
                                    state    <= DONE_S;
                                    done     <= 1'b1;
                                    cpu_hold <= 1'b0;
                                end else begin
                                    state <= ERR_S;
                                    error <= 1'b1;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
`timescale 1ns/1ps
// Self-checking bench for imem_program_loader: directed scenarios plus random
// loads checked against a stream-level model of the expected writes and status.
module tb_imem_program_loader;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [7:0]  load_count;

    int compared = 0;
    int mismatched = 0;

    logic [15:0] wordBuf [0:15];
    logic [23:0] capQ [$];
    logic [23:0] expQ [$];
    logic        expDone;
    logic        expError;
    logic [7:0]  expCount = 8'd0;

    imem_program_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold),
        .done(done),
        .error(error),
        .load_count(load_count)
    );

    always #5 clk = ~clk;

    // Write strobes are captured mid-cycle so the scoreboard sees each pulse once.
    always @(negedge clk) begin
        if (imem_we) capQ.push_back({imem_addr, imem_wdata});
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        bit accepted;
        accepted = 1'b0;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 40 && !accepted; k++) begin
            if (in_ready) accepted = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!accepted) checkOutput("handshake", 32'd0, 32'd1);
    endtask

    // Sends one full image: LEN, LEN word pairs from wordBuf, then CHK^chkMask.
    task automatic applyStimulus(input logic [7:0] lenByte, input logic [7:0] chkMask,
                                 input int gapMin, input int gapMax);
        logic [7:0] chk;
        capQ.delete();
        expQ.delete();
        pulseStart();
        chk = lenByte;
        sendByte(lenByte, int'($urandom_range(gapMax, gapMin)));
        if (lenByte == 8'd0 || int'(lenByte) >= DEPTH) begin
            expDone  = 1'b0;
            expError = 1'b1;
            return;
        end
        for (int i = 0; i < int'(lenByte); i++) begin
            sendByte(wordBuf[i][15:8], int'($urandom_range(gapMax, gapMin)));
            sendByte(wordBuf[i][7:0], int'($urandom_range(gapMax, gapMin)));
            chk = chk ^ wordBuf[i][15:8] ^ wordBuf[i][7:0];
            expQ.push_back({i[7:0], wordBuf[i]});
        end
        sendByte(chk ^ chkMask, int'($urandom_range(gapMax, gapMin)));
        expCount = lenByte;
        expDone  = (chkMask == 8'h00);
        expError = !expDone;
    endtask

    task automatic checkLoad(input string tag);
        checkOutput({tag, "/done"}, 32'(done), 32'(expDone));
        checkOutput({tag, "/error"}, 32'(error), 32'(expError));
        checkOutput({tag, "/cpu_hold"}, 32'(cpu_hold), 32'(!expDone));
        checkOutput({tag, "/in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "/load_count"}, 32'(load_count), 32'(expCount));
        checkOutput({tag, "/nwrites"}, 32'(capQ.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            if (i < capQ.size())
                checkOutput($sformatf("%s/write%0d", tag, i), 32'(capQ[i]), 32'(expQ[i]));
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "/in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "/imem_we"}, 32'(imem_we), 32'd0);
        checkOutput({tag, "/imem_addr"}, 32'(imem_addr), 32'd0);
        checkOutput({tag, "/imem_wdata"}, 32'(imem_wdata), 32'd0);
        checkOutput({tag, "/cpu_hold"}, 32'(cpu_hold), 32'd1);
        checkOutput({tag, "/done"}, 32'(done), 32'd0);
        checkOutput({tag, "/error"}, 32'(error), 32'd0);
        checkOutput({tag, "/load_count"}, 32'(load_count), 32'd0);
    endtask

    initial begin
        logic [7:0] rlen;
        logic [7:0] rmask;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("por");
        reset = 1'b0;
        @(posedge clk); #1;

        // start coincident with a valid byte in IDLE: byte held, not consumed
        $display("[TB] single word with start/in_valid overlap");
        capQ.delete();
        in_valid = 1'b1;
        in_data  = 8'h01;
        start    = 1'b1;
        checkOutput("idle/in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("len_s/in_ready", 32'(in_ready), 32'd1);
        sendByte(8'h01, 0);
        sendByte(8'h12, 0);
        sendByte(8'h34, 0);
        sendByte(8'h27, 0);
        expQ.delete();
        expQ.push_back({8'h00, 16'h1234});
        expDone  = 1'b1;
        expError = 1'b0;
        expCount = 8'd1;
        checkLoad("single");

        // Three words with random gaps
        $display("[TB] three words with gaps");
        wordBuf[0] = 16'hA001;
        wordBuf[1] = 16'hB002;
        wordBuf[2] = 16'hC003;
        applyStimulus(8'd3, 8'h00, 0, TIMEOUT - 1);
        checkLoad("three");

        // Bad checksum (0x28 instead of 0x27)
        $display("[TB] bad checksum");
        wordBuf[0] = 16'h1234;
        applyStimulus(8'd1, 8'h0F, 0, 0);
        checkLoad("badchk");
        pulseStart();
        checkOutput("restart/error", 32'(error), 32'd0);
        checkOutput("restart/cpu_hold", 32'(cpu_hold), 32'd1);

        // Length 0 on the already-started load
        $display("[TB] length errors");
        capQ.delete();
        expQ.delete();
        sendByte(8'h00, 0);
        expDone  = 1'b0;
        expError = 1'b1;
        checkLoad("len0");
        applyStimulus(8'h10, 8'h00, 0, 0);
        checkLoad("lendepth");

        // Done cleared by a new start
        wordBuf[0] = 16'h5AA5;
        applyStimulus(8'd1, 8'h00, 0, 3);
        checkLoad("predone");
        pulseStart();
        checkOutput("donestart/done", 32'(done), 32'd0);
        checkOutput("donestart/cpu_hold", 32'(cpu_hold), 32'd1);
        sendByte(8'h00, 0);

        // Timeout: 16 idle cycles after HI
        $display("[TB] timeout");
        capQ.delete();
        pulseStart();
        sendByte(8'd2, 0);
        sendByte(8'h77, 0);
        repeat (TIMEOUT - 1) begin
            @(posedge clk); #1;
        end
        checkOutput("timeout/before", 32'(error), 32'd0);
        @(posedge clk); #1;
        checkOutput("timeout/error", 32'(error), 32'd1);
        checkOutput("timeout/in_ready", 32'(in_ready), 32'd0);
        checkOutput("timeout/nwrites", 32'(capQ.size()), 32'd0);

        // Every byte arrives on the last allowed idle cycle: no timeout
        wordBuf[0] = 16'h7788;
        wordBuf[1] = 16'h99AA;
        applyStimulus(8'd2, 8'h00, TIMEOUT - 1, TIMEOUT - 1);
        checkLoad("edge_gap");

        // Asynchronous reset mid-load while a write strobe is visible
        $display("[TB] reset mid-load");
        capQ.delete();
        pulseStart();
        sendByte(8'd3, 0);
        sendByte(8'hA0, 0);
        sendByte(8'h01, 0);
        checkOutput("prereset/imem_we", 32'(imem_we), 32'd1);
        checkOutput("prereset/imem_wdata", 32'(imem_wdata), 32'hA001);
        #1 reset = 1'b1;
        #1 checkResetValues("midreset");
        #1 reset = 1'b0;
        expCount = 8'd0;
        @(posedge clk); #1;

        // Random loads against the model
        $display("[TB] random loads");
        for (int n = 0; n < 8; n++) begin
            rlen = 8'($urandom_range(DEPTH - 1, 1));
            for (int i = 0; i < DEPTH; i++) wordBuf[i] = 16'($urandom);
            rmask = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            applyStimulus(rlen, rmask, 0, TIMEOUT - 1);
            checkLoad($sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
